// File: rtl/store_packer_pkg.sv
// store_packer_pkg: width codes, exception codes and packed-lane type shared by
// the store packer and its lane generator.
`default_nettype none

package store_packer_pkg;

  typedef enum logic [1:0] {
    ST_WORD = 2'd0,
    ST_HALF = 2'd1,
    ST_BYTE = 2'd2,
    ST_RSVD = 2'd3
  } st_width_e;

  localparam logic [4:0] EXC_ADES_CODE = 5'd5;
  localparam logic [4:0] EXC_RI_CODE   = 5'd10;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } lane_t;

  function automatic logic [3:0] byte_be(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_gen.sv
// store_lane_gen: combinational store narrowing {addr,data,width} -> write word,
// byte enables and an illegal/exception-code flag.
`default_nettype none

module store_lane_gen
  import store_packer_pkg::*;
#(
  parameter logic [4:0] EXC_ADES = EXC_ADES_CODE,
  parameter logic [4:0] EXC_RI   = EXC_RI_CODE
) (
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  width_i,
  output lane_t       lane_o,
  output logic        illegal_o,
  output logic [4:0]  code_o
);

  always_comb begin
    lane_o    = '0;
    illegal_o = 1'b0;
    code_o    = 5'd0;
    case (st_width_e'(width_i))
      ST_WORD: begin
        lane_o.wdata = data_i;
        lane_o.be    = 4'b1111;
        if (addr_lo_i != 2'b00) begin
          illegal_o = 1'b1;
          code_o    = EXC_ADES;
        end
      end
      ST_HALF: begin
        lane_o.wdata = {2{data_i[15:0]}};
        lane_o.be    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        if (addr_lo_i[0]) begin
          illegal_o = 1'b1;
          code_o    = EXC_ADES;
        end
      end
      ST_BYTE: begin
        lane_o.wdata = {4{data_i[7:0]}};
        lane_o.be    = byte_be(addr_lo_i);
      end
      default: begin
        illegal_o = 1'b1;
        code_o    = EXC_RI;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_packer.sv
// store_packer: aligns GPR store operands into word writes + byte enables behind a
// 2-entry in-order buffer; misaligned or reserved-width stores raise a one-cycle exception.
`default_nettype none

module store_packer
  import store_packer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [4:0]  EXC_ADES = EXC_ADES_CODE,
  parameter logic [4:0]  EXC_RI   = EXC_RI_CODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_width,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_wdata,
  output logic [3:0]        out_be,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic [ADDR_W-1:0] exc_addr
);

  lane_t       lane_w;
  logic        illegal_w;
  logic [4:0]  code_w;

  store_lane_gen #(
    .EXC_ADES (EXC_ADES),
    .EXC_RI   (EXC_RI)
  ) u_lane_gen (
    .addr_lo_i (in_addr[1:0]),
    .data_i    (in_data),
    .width_i   (in_width),
    .lane_o    (lane_w),
    .illegal_o (illegal_w),
    .code_o    (code_w)
  );

  logic [ADDR_W-3:0] addr_q [2];
  lane_t             lane_q [2];
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              exc_valid_q, exc_valid_d;
  logic [4:0]        exc_code_q;
  logic [ADDR_W-1:0] exc_addr_q;

  logic accept, push, pop;

  // in_ready comes straight from the count register, so out_ready never reaches it.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid & in_ready & ~flush;
  assign push      = accept & ~illegal_w;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    exc_valid_d = accept & illegal_w;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= 5'd0;
      exc_addr_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        lane_q[i] <= '0;
      end
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      exc_valid_q <= exc_valid_d;
      if (exc_valid_d) begin
        exc_code_q <= code_w;
        exc_addr_q <= in_addr;
      end
      if (push) begin
        addr_q[wr_ptr_q] <= in_addr[ADDR_W-1:2];
        lane_q[wr_ptr_q] <= lane_w;
      end
    end
  end

  assign out_addr  = {addr_q[rd_ptr_q], 2'b00};
  assign out_wdata = lane_q[rd_ptr_q].wdata;
  assign out_be    = lane_q[rd_ptr_q].be;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;
  assign exc_addr  = exc_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_store_packer.sv
// tb_store_packer: directed self-checking bench for store_packer with
// hand-computed expected packing, flow-control, flush and reset results.
`default_nettype none

module tb_store_packer;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, exc_valid;
  logic [31:0] in_addr, in_data, out_addr, out_wdata, exc_addr;
  logic [1:0]  in_width;
  logic [3:0]  out_be;
  logic [4:0]  exc_code;

  int n_chk = 0;
  int n_err = 0;

  store_packer #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_width  (in_width),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_wdata (out_wdata),
    .out_be    (out_be),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .exc_addr  (exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs changed afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] w);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_width = w;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'h10, 32'h0000_00C3, 2'd2, 32'h10, 32'hC3C3_C3C3, 4'b0001};
    vecs[1] = '{32'h11, 32'h0000_0011, 2'd2, 32'h10, 32'h1111_1111, 4'b0010};
    vecs[2] = '{32'h12, 32'h0000_0022, 2'd2, 32'h10, 32'h2222_2222, 4'b0100};
    vecs[3] = '{32'h20, 32'hFFFF_1234, 2'd1, 32'h20, 32'h1234_1234, 4'b0011};
    vecs[4] = '{32'h30, 32'hCAFE_F00D, 2'd0, 32'h30, 32'hCAFE_F00D, 4'b1111};
    vecs[5] = '{32'h32, 32'h0000_5678, 2'd1, 32'h30, 32'h5678_5678, 4'b1100};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    #12;
    chk("rst in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_addr",  out_addr,           32'h0);
    chk("rst out_wdata", out_wdata,          32'h0);
    chk("rst out_be",    {28'd0, out_be},    32'h0);
    chk("rst exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("rst exc_code",  {27'd0, exc_code},  32'd0);
    chk("rst exc_addr",  exc_addr,           32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // SB to top byte lane
    drive(1'b1, 32'h103, 32'h1234_56AB, 2'd2);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("sb out_valid", {31'd0, out_valid}, 32'd1);
    chk("sb out_addr",  out_addr,           32'h100);
    chk("sb out_wdata", out_wdata,          32'hABAB_ABAB);
    chk("sb out_be",    {28'd0, out_be},    32'h8);
    chk("sb exc_valid", {31'd0, exc_valid}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("sb popped", {31'd0, out_valid}, 32'd0);

    // SH aligned upper half
    drive(1'b1, 32'h202, 32'hDEAD_BEEF, 2'd1);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("sh out_addr",  out_addr,        32'h200);
    chk("sh out_wdata", out_wdata,       32'hBEEF_BEEF);
    chk("sh out_be",    {28'd0, out_be}, 32'hC);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // SH misaligned -> AdES
    drive(1'b1, 32'h201, 32'hDEAD_BEEF, 2'd1);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("ades exc_valid", {31'd0, exc_valid}, 32'd1);
    chk("ades exc_code",  {27'd0, exc_code},  32'd5);
    chk("ades exc_addr",  exc_addr,           32'h201);
    chk("ades out_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("ades pulse end", {31'd0, exc_valid}, 32'd0);
    chk("ades code held", {27'd0, exc_code},  32'd5);
    chk("ades no write",  {31'd0, out_valid}, 32'd0);

    // Three SW back-to-back into a stalled port
    drive(1'b1, 32'h400, 32'hAAAA_0001, 2'd0);
    step();
    chk("sw1 in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h404, 32'hBBBB_0002, 2'd0);
    step();
    chk("sw2 in_ready", {31'd0, in_ready}, 32'd0);
    chk("sw2 head addr", out_addr, 32'h400);
    drive(1'b1, 32'h408, 32'hCCCC_0003, 2'd0);
    step();
    chk("sw3 blocked in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall head addr",  out_addr,  32'h400);
    chk("stall head wdata", out_wdata, 32'hAAAA_0001);
    out_ready = 1'b1;
    step();
    chk("drain1 addr",     out_addr,           32'h404);
    chk("drain1 wdata",    out_wdata,          32'hBBBB_0002);
    chk("drain1 in_ready", {31'd0, in_ready},  32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("drain2 valid", {31'd0, out_valid}, 32'd1);
    chk("drain2 addr",  out_addr,           32'h408);
    chk("drain2 wdata", out_wdata,          32'hCCCC_0003);
    step();
    chk("drain empty", {31'd0, out_valid}, 32'd0);

    // Packing table streamed at one store per cycle
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].addr, vecs[i].data, vecs[i].width);
      step();
      chk($sformatf("vec%0d valid", i), {31'd0, out_valid},     32'd1);
      chk($sformatf("vec%0d addr", i),  out_addr,               vecs[i].exp_addr);
      chk($sformatf("vec%0d wdata", i), out_wdata,              vecs[i].exp_wdata);
      chk($sformatf("vec%0d be", i),    {28'd0, out_be},        {28'd0, vecs[i].exp_be});
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    step();
    out_ready = 1'b0;
    chk("stream empty", {31'd0, out_valid}, 32'd0);

    // Reserved width
    drive(1'b1, 32'h300, 32'h5555_5555, 2'd3);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("ri exc_valid", {31'd0, exc_valid}, 32'd1);
    chk("ri exc_code",  {27'd0, exc_code},  32'd10);
    chk("ri exc_addr",  exc_addr,           32'h300);
    chk("ri out_valid", {31'd0, out_valid}, 32'd0);

    // Flush with full buffer while a request is offered
    drive(1'b1, 32'h500, 32'h1, 2'd0);
    step();
    drive(1'b1, 32'h504, 32'h2, 2'd0);
    step();
    chk("pre-flush full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h508, 32'h3, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush2 out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush2 in_ready",  {31'd0, in_ready},  32'd1);

    // Flush with one entry and a legal accept in the same cycle
    drive(1'b1, 32'h600, 32'h6, 2'd0);
    step();
    drive(1'b1, 32'h604, 32'h7, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("flush1 out_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("flush1 discarded", {31'd0, out_valid}, 32'd0);

    // Flush suppresses an exception pulse but keeps the last code/addr
    drive(1'b1, 32'h701, 32'h0, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("flush exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("flush exc_code",  {27'd0, exc_code},  32'd10);
    chk("flush exc_addr",  exc_addr,           32'h300);

    // Async reset while a write is stalled at the head
    drive(1'b1, 32'h800, 32'h8888_8888, 2'd0);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("pre-rst out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid-rst in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid-rst out_addr",  out_addr,           32'h0);
    chk("mid-rst out_wdata", out_wdata,          32'h0);
    chk("mid-rst out_be",    {28'd0, out_be},    32'h0);
    chk("mid-rst exc_code",  {27'd0, exc_code},  32'd0);
    chk("mid-rst exc_addr",  exc_addr,           32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("post-rst out_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
